// File: rtl/dsss_corr_despreader_param.sv
// dsss_corr_despreader_param: I/Q matched-filter despreader with loadable taps,
// multiply/adder-tree pipeline, output saturation and symbol-rate decimation.
module dsss_corr_despreader_param #(
  parameter int N_TAPS = 20,
  parameter int IN_W   = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32,
  parameter int SPS    = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      coef_wr_en,
  input  logic [$clog2(N_TAPS)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]         coef_wr_data,
  input  logic [IN_W-1:0]           sample_i,
  input  logic [IN_W-1:0]           sample_q,
  input  logic                      sample_valid,
  input  logic                      sym_align,
  output logic [OUT_W-1:0]          corr_i,
  output logic [OUT_W-1:0]          corr_q,
  output logic                      corr_valid,
  output logic                      corr_sat,
  output logic [OUT_W-1:0]          sym_i,
  output logic [OUT_W-1:0]          sym_q,
  output logic                      sym_valid
);

  localparam int PW  = IN_W + COEF_W;
  localparam int SW  = PW + $clog2(N_TAPS);
  localparam int PHW = $clog2(SPS);

  logic signed [IN_W-1:0]   hist_re_q [N_TAPS];
  logic signed [IN_W-1:0]   hist_im_q [N_TAPS];
  logic signed [COEF_W-1:0] coef_q    [N_TAPS];
  logic signed [COEF_W-1:0] coef_s_q  [N_TAPS];
  logic signed [PW-1:0]     prod_re_q [N_TAPS];
  logic signed [PW-1:0]     prod_im_q [N_TAPS];
  logic signed [SW-1:0]     sum_re_d, sum_im_d;
  logic signed [SW-1:0]     sum_re_q, sum_im_q;
  logic [OUT_W-1:0]         corr_re_d, corr_im_d;
  logic [OUT_W-1:0]         corr_re_q, corr_im_q;
  logic [OUT_W-1:0]         sym_re_q, sym_im_q;
  logic                     sat_re, sat_im;
  logic [2:0]               vld_q;
  logic                     corr_valid_q, corr_sat_q;
  logic [PHW-1:0]           phase_q;

  always_comb begin
    sum_re_d = '0;
    sum_im_d = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      sum_re_d = sum_re_d + SW'(prod_re_q[k]);
      sum_im_d = sum_im_d + SW'(prod_im_q[k]);
    end
  end

  if (OUT_W >= SW) begin : g_ext
    assign corr_re_d = OUT_W'(sum_re_q);
    assign corr_im_d = OUT_W'(sum_im_q);
    assign sat_re    = 1'b0;
    assign sat_im    = 1'b0;
  end else begin : g_sat
    // Bits above the output sign must all match it, else clamp.
    function automatic logic [OUT_W:0] clamp(input logic [SW-1:0] s);
      logic [SW-OUT_W:0] top;
      top = s[SW-1:OUT_W-1];
      if (&top || ~|top) return {1'b0, s[OUT_W-1:0]};
      else if (s[SW-1])  return {2'b11, {(OUT_W-1){1'b0}}};
      else               return {2'b10, {(OUT_W-1){1'b1}}};
    endfunction
    assign {sat_re, corr_re_d} = clamp(sum_re_q);
    assign {sat_im, corr_im_d} = clamp(sum_im_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_TAPS; k++) begin
        hist_re_q[k] <= '0;
        hist_im_q[k] <= '0;
        coef_q[k]    <= '0;
        coef_s_q[k]  <= '0;
        prod_re_q[k] <= '0;
        prod_im_q[k] <= '0;
      end
      sum_re_q     <= '0;
      sum_im_q     <= '0;
      vld_q        <= '0;
      corr_valid_q <= 1'b0;
      corr_sat_q   <= 1'b0;
      corr_re_q    <= '0;
      corr_im_q    <= '0;
      sym_re_q     <= '0;
      sym_im_q     <= '0;
      phase_q      <= '0;
    end else begin
      if (sample_valid) begin
        hist_re_q[0] <= sample_i;
        hist_im_q[0] <= sample_q;
        for (int k = 1; k < N_TAPS; k++) begin
          hist_re_q[k] <= hist_re_q[k-1];
          hist_im_q[k] <= hist_im_q[k-1];
        end
      end
      if (coef_wr_en && 32'(coef_wr_addr) < N_TAPS)
        coef_q[coef_wr_addr] <= coef_wr_data;
      // Lagged copy so a write on the capture edge misses that sample.
      for (int k = 0; k < N_TAPS; k++) begin
        coef_s_q[k]  <= coef_q[k];
        prod_re_q[k] <= hist_re_q[k] * coef_s_q[k];
        prod_im_q[k] <= hist_im_q[k] * coef_s_q[k];
      end
      sum_re_q     <= sum_re_d;
      sum_im_q     <= sum_im_d;
      vld_q        <= {vld_q[1:0], sample_valid};
      corr_valid_q <= vld_q[2];
      corr_sat_q   <= vld_q[2] & (sat_re | sat_im);
      if (vld_q[2]) begin
        corr_re_q <= corr_re_d;
        corr_im_q <= corr_im_d;
      end
      if (sym_valid) begin
        sym_re_q <= corr_re_q;
        sym_im_q <= corr_im_q;
      end
      if (corr_valid_q) begin
        if (sym_align)
          phase_q <= PHW'(1);
        else if (phase_q == PHW'(SPS - 1))
          phase_q <= '0;
        else
          phase_q <= phase_q + PHW'(1);
      end
    end
  end

  assign corr_i     = corr_re_q;
  assign corr_q     = corr_im_q;
  assign corr_valid = corr_valid_q;
  assign corr_sat   = corr_sat_q;
  assign sym_valid  = corr_valid_q && (phase_q == '0 || sym_align);
  assign sym_i      = sym_valid ? corr_re_q : sym_re_q;
  assign sym_q      = sym_valid ? corr_im_q : sym_im_q;

endmodule

// File: tb/tb_dsss_corr_despreader_param.sv
// tb_dsss_corr_despreader_param: random and directed stimulus against a
// queue-based correlator/decimator reference model.
module tb_dsss_corr_despreader_param;

  localparam int N   = 11;
  localparam int IW  = 16;
  localparam int CW  = 16;
  localparam int OW  = 20;
  localparam int SPS = 11;
  localparam int AW  = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          coef_wr_en = 1'b0;
  logic [AW-1:0] coef_wr_addr = '0;
  logic [CW-1:0] coef_wr_data = '0;
  logic [IW-1:0] sample_i = '0;
  logic [IW-1:0] sample_q = '0;
  logic          sample_valid = 1'b0;
  logic          sym_align = 1'b0;
  logic [OW-1:0] corr_i, corr_q, sym_i, sym_q;
  logic          corr_valid, corr_sat, sym_valid;

  dsss_corr_despreader_param #(
    .N_TAPS(N), .IN_W(IW), .COEF_W(CW), .OUT_W(OW), .SPS(SPS)
  ) dut (
    .clk(clk), .reset(reset),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .sample_i(sample_i), .sample_q(sample_q),
    .sample_valid(sample_valid), .sym_align(sym_align),
    .corr_i(corr_i), .corr_q(corr_q),
    .corr_valid(corr_valid), .corr_sat(corr_sat),
    .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint due;
    longint i;
    longint q;
    bit     sat;
  } exp_t;

  exp_t   expq[$];
  longint hq_i[$], hq_q[$];
  longint m_coef[N];
  longint seen_i[$];
  bit     seen_sat[$];
  int     sym_beats[$];
  longint edges = 0;
  int     checks = 0, failures = 0;
  int     beats = 0, anchor = 0, align_at = -1;
  longint last_i = 0, last_q = 0, sym_li = 0, sym_lq = 0;
  int     bk[11] = '{1, -1, 1, 1, -1, 1, 1, 1, -1, -1, -1};

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint clampv(longint v, output bit s);
    longint hi, lo;
    hi = (64'sd1 <<< (OW - 1)) - 1;
    lo = -(64'sd1 <<< (OW - 1));
    s = (v > hi) || (v < lo);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic longint rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return r;
  endfunction

  task automatic flush();
    expq.delete();
    hq_i.delete();
    hq_q.delete();
    for (int k = 0; k < N; k++) begin
      hq_i.push_back(0);
      hq_q.push_back(0);
      m_coef[k] = 0;
    end
    beats = 0; anchor = 0;
    last_i = 0; last_q = 0; sym_li = 0; sym_lq = 0;
  endtask

  task automatic model_sample(longint si, longint sq);
    exp_t   e;
    longint ai = 0, aq = 0;
    bit     s1, s2;
    hq_i.push_front(si); void'(hq_i.pop_back());
    hq_q.push_front(sq); void'(hq_q.pop_back());
    for (int k = 0; k < N; k++) begin
      ai += hq_i[k] * m_coef[k];
      aq += hq_q[k] * m_coef[k];
    end
    e.due = edges + 4;
    e.i   = clampv(ai, s1);
    e.q   = clampv(aq, s2);
    e.sat = s1 | s2;
    expq.push_back(e);
  endtask

  task automatic step(bit v, longint si = 0, longint sq = 0, bit we = 0,
                      int addr = 0, longint wd = 0, bit al = 0);
    logic [31:0] a32;
    logic [63:0] s64i, s64q, w64;
    @(posedge clk); #1;
    a32 = addr; s64i = si; s64q = sq; w64 = wd;
    sample_valid = v;
    sample_i     = s64i[IW-1:0];
    sample_q     = s64q[IW-1:0];
    coef_wr_en   = we;
    coef_wr_addr = a32[AW-1:0];
    coef_wr_data = w64[CW-1:0];
    sym_align    = (align_at >= 0) ? (corr_valid && beats == align_at) : al;
    if (v) model_sample(si, sq);
    if (we && addr < N) m_coef[addr] = wd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    sample_valid = 0; coef_wr_en = 0; sym_align = 0;
    flush();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_sv;
    if (!reset) begin
      exp_sv = 0;
      if (corr_valid) begin
        if (expq.size() == 0) chk("cv_spurious", corr_valid, 0);
        else begin
          e = expq.pop_front();
          chk("cv_latency", edges, e.due);
          chk("corr_i", $signed(corr_i), e.i);
          chk("corr_q", $signed(corr_q), e.q);
          chk("corr_sat", corr_sat, e.sat);
          last_i = e.i; last_q = e.q;
          seen_i.push_back($signed(corr_i));
          seen_sat.push_back(corr_sat);
          exp_sv = sym_align || ((beats - anchor) % SPS == 0);
          if (sym_align) anchor = beats;
          if (exp_sv) begin sym_li = e.i; sym_lq = e.q; end
          if (sym_valid) sym_beats.push_back(beats);
          beats++;
        end
      end else begin
        if (expq.size() > 0 && expq[0].due <= edges) begin
          chk("cv_missing", corr_valid, 1);
          void'(expq.pop_front());
        end
        chk("corr_sat_idle", corr_sat, 0);
        chk("corr_i_hold", $signed(corr_i), last_i);
        chk("corr_q_hold", $signed(corr_q), last_q);
      end
      chk("sym_valid", sym_valid, exp_sv);
      chk("sym_i", $signed(sym_i), sym_li);
      chk("sym_q", $signed(sym_q), sym_lq);
    end
  end

  task automatic load_barker();
    for (int j = 0; j < 11; j++) step(0, 0, 0, 1, 10 - j, bk[j]);
  endtask

  longint ref_i[$];

  initial begin
    flush();
    #23;
    chk("rst_corr_i", corr_i, 0);
    chk("rst_corr_valid", corr_valid, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_i", sym_i, 0);
    @(posedge clk); #1 reset = 1'b0;

    // mid-stream reset
    for (int k = 0; k < N; k++) step(0, 0, 0, 1, k, rnd16());
    for (int j = 0; j < 5; j++) step(1, rnd16(), rnd16());
    #2 reset = 1'b1;
    sample_valid = 0; coef_wr_en = 0;
    flush();
    #1;
    chk("mrst_corr_i", corr_i, 0);
    chk("mrst_corr_q", corr_q, 0);
    chk("mrst_corr_valid", corr_valid, 0);
    chk("mrst_corr_sat", corr_sat, 0);
    chk("mrst_sym_i", sym_i, 0);
    chk("mrst_sym_q", sym_q, 0);
    chk("mrst_sym_valid", sym_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen_i.delete();
    idle(10);
    chk("mrst_quiet", seen_i.size(), 0);
    step(1, 7, 7);
    idle(6);
    chk("mrst_one_out", seen_i.size(), 1);

    // Barker, gap-free then gapped
    do_reset(); load_barker(); seen_i.delete();
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 11; j++) step(1, bk[j] * 100, 0);
    idle(6);
    chk("bk_count", seen_i.size(), 22);
    chk("bk_peak0", seen_i.size() > 10 ? seen_i[10] : -1, 1100);
    chk("bk_peak1", seen_i.size() > 21 ? seen_i[21] : -1, 1100);
    ref_i = seen_i;
    do_reset(); load_barker(); seen_i.delete();
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 11; j++) begin
        idle($urandom_range(0, 3));
        step(1, bk[j] * 100, 0);
      end
    idle(6);
    chk("gap_count", seen_i.size(), 22);
    for (int j = 0; j < 22; j++)
      chk("gap_eq", seen_i.size() > j ? seen_i[j] : -1, ref_i[j]);

    // coefficient write timing
    do_reset();
    step(0, 0, 0, 1, 0, 1);
    seen_i.delete();
    step(1, 10, 0, 1, 0, 5);
    step(1, 3, 0);
    step(1, 3, 0, 1, N, 99);
    step(1, 3, 0);
    idle(6);
    chk("cw_old", seen_i.size() > 0 ? seen_i[0] : -1, 10);
    chk("cw_new", seen_i.size() > 1 ? seen_i[1] : -1, 15);
    chk("cw_oob", seen_i.size() > 3 ? seen_i[3] : -1, 15);

    // saturation
    do_reset();
    for (int k = 0; k < N; k++) step(0, 0, 0, 1, k, 32767);
    seen_i.delete(); seen_sat.delete();
    for (int j = 0; j < N; j++) step(1, 32767, 0);
    idle(6);
    chk("sat_pos", seen_i.size() > 0 ? seen_i[$] : 0, 524287);
    chk("sat_pos_flag", seen_sat.size() > 0 ? seen_sat[$] : 0, 1);
    for (int j = 0; j < N; j++) step(1, -32768, 0);
    idle(6);
    chk("sat_neg", seen_i.size() > 0 ? seen_i[$] : 0, -524288);
    chk("sat_neg_flag", seen_sat.size() > 0 ? seen_sat[$] : 0, 1);

    // decimation with forced alignment on beat 7
    do_reset();
    for (int k = 0; k < N; k++) step(0, 0, 0, 1, k, $urandom_range(0, 50));
    sym_beats.delete();
    align_at = 7;
    for (int j = 0; j < 40; j++) step(1, rnd16(), rnd16());
    idle(6);
    align_at = -1;
    chk("dec_n", sym_beats.size() >= 4, 1);
    chk("dec_b0", sym_beats.size() > 0 ? sym_beats[0] : -1, 0);
    chk("dec_b1", sym_beats.size() > 1 ? sym_beats[1] : -1, 7);
    chk("dec_b2", sym_beats.size() > 2 ? sym_beats[2] : -1, 18);
    chk("dec_b3", sym_beats.size() > 3 ? sym_beats[3] : -1, 29);

    // random traffic
    do_reset();
    for (int j = 0; j < 1500; j++)
      step($urandom_range(0, 3) != 0, rnd16(), rnd16(),
           $urandom_range(0, 7) == 0, $urandom_range(0, 15), rnd16(),
           $urandom_range(0, 9) == 0);
    idle(8);
    chk("drain", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
